// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the uart_dbg arbiter family: state encoding, tag base, index sizing helper.
package uart_dbg_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        XFER = 2'd2
    } state_t;

    localparam logic [7:0] TAG_BASE = 8'h30;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/uart_dbg_arb_if.sv
// Requester lanes and uart_dbg queue port bundled for the arbiter; slave modport is the arbiter side.
interface uart_dbg_arb_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   in_valid;
    logic [8*NUM_REQ-1:0] in_data;
    logic [NUM_REQ-1:0]   in_last;
    logic [NUM_REQ-1:0]   in_ready;
    logic                 dbg_wr;
    logic [7:0]           dbg_msg;
    logic                 dbg_full;
    logic [NUM_REQ-1:0]   grant;
    logic                 busy;

    modport master (
        output in_valid, in_data, in_last, dbg_full,
        input  in_ready, dbg_wr, dbg_msg, grant, busy
    );

    modport slave (
        input  in_valid, in_data, in_last, dbg_full,
        output in_ready, dbg_wr, dbg_msg, grant, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set request at or after ptr, wrapping modulo N.
module rr_pick
    import uart_dbg_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    always_comb begin
        rot = {req, req} >> ptr;
        off = '0;
        any = 1'b0;
        // Descending scan so the lowest rotated offset wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
                any = 1'b1;
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
        idx = sum[IW-1:0];
    end
endmodule

// File: rtl/uart_dbg_arb.sv
// Round-robin arbiter feeding one uart_dbg queue a whole message at a time.
// UART_DBG_ARB_TAG_EN: prefix each grant with an ASCII source-ID byte.
module uart_dbg_arb
    import uart_dbg_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int MAX_LEN = 64
) (
    input  logic           clk,
    input  logic           reset,
    uart_dbg_arb_if.slave  bus
);
    localparam int IW = clog2(NUM_REQ);

    state_t        state, state_nx;
    logic [IW-1:0] gnt_idx, gnt_idx_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [7:0]    len_cnt, len_cnt_nx;
    logic [IW-1:0] pick_idx;
    logic          pick_any;
    logic          accept;
    logic          last_hit;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req (bus.in_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign accept   = (state == XFER) & bus.in_valid[gnt_idx] & ~bus.dbg_full;
    // Byte about to be accepted either closes the frame or hits the length cap.
    assign last_hit = bus.in_last[gnt_idx] | (len_cnt == 8'(MAX_LEN - 1));

    always_comb begin
        state_nx     = state;
        gnt_idx_nx   = gnt_idx;
        rr_ptr_nx    = rr_ptr;
        len_cnt_nx   = len_cnt;
        bus.in_ready = '0;
        bus.dbg_wr   = 1'b0;
        bus.dbg_msg  = 8'h00;
        bus.grant    = '0;
        bus.busy     = (state != IDLE);
        if (state != IDLE) bus.grant[gnt_idx] = 1'b1;

        case (state)
            IDLE: begin
                if (pick_any) begin
                    gnt_idx_nx = pick_idx;
                    len_cnt_nx = 8'h00;
`ifdef UART_DBG_ARB_TAG_EN
                    state_nx   = TAG;
`else
                    state_nx   = XFER;
`endif
                end
            end
`ifdef UART_DBG_ARB_TAG_EN
            TAG: begin
                bus.dbg_wr  = ~bus.dbg_full;
                bus.dbg_msg = TAG_BASE + 8'(gnt_idx);
                if (!bus.dbg_full) state_nx = XFER;
            end
`endif
            XFER: begin
                bus.in_ready[gnt_idx] = ~bus.dbg_full;
                bus.dbg_wr            = accept;
                bus.dbg_msg           = bus.in_data[{gnt_idx, 3'b000} +: 8];
                if (accept) begin
                    len_cnt_nx = len_cnt + 8'd1;
                    if (last_hit) begin
                        state_nx  = IDLE;
                        rr_ptr_nx = (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            gnt_idx <= '0;
            rr_ptr  <= '0;
            len_cnt <= 8'h00;
        end else begin
            state   <= state_nx;
            gnt_idx <= gnt_idx_nx;
            rr_ptr  <= rr_ptr_nx;
            len_cnt <= len_cnt_nx;
        end
    end
endmodule

// File: tb/tb_uart_dbg_arb.sv
// Randomized bench for uart_dbg_arb against a message-level arbitration model.
module tb_uart_dbg_arb;
    localparam int N    = 4;
    localparam int ML   = 4;
    localparam int QLEN = 400;
`ifdef UART_DBG_ARB_TAG_EN
    localparam bit TAG_ON = 1'b1;
`else
    localparam bit TAG_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_dbg_arb_if #(.NUM_REQ(N)) bus ();

    uart_dbg_arb #(.NUM_REQ(N), .MAX_LEN(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [8:0] lane_mem [N][QLEN];
    int         head [N];

    int m_owner;
    int m_ptr;
    int m_cnt;
    bit m_tag_due;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit force_full);
        logic [N-1:0]   v, l, e_rdy, e_gnt;
        logic [8*N-1:0] d;
        logic           ff, e_wr, e_busy, acc;
        logic [7:0]     e_msg;
        @(negedge clk);
        reset = 1'b0;
        ff = force_full | ($urandom_range(0, 3) == 0);
        for (int i = 0; i < N; i++) begin
            if (head[i] < QLEN && $urandom_range(0, 3) != 0) begin
                v[i] = 1'b1;
                d[8*i +: 8] = lane_mem[i][head[i]][7:0];
                l[i] = lane_mem[i][head[i]][8];
            end else begin
                v[i] = 1'b0;
                d[8*i +: 8] = 8'($urandom);
                l[i] = 1'($urandom);
            end
        end
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.dbg_full = ff;
        #1;
        e_rdy = '0; e_gnt = '0; e_wr = 1'b0; e_busy = 1'b0; e_msg = 8'h00; acc = 1'b0;
        if (m_owner >= 0) begin
            e_busy = 1'b1;
            e_gnt[m_owner] = 1'b1;
            if (m_tag_due) begin
                e_wr  = !ff;
                e_msg = 8'h30 + 8'(m_owner);
            end else begin
                e_rdy[m_owner] = !ff;
                e_wr  = v[m_owner] & !ff;
                e_msg = d[8*m_owner +: 8];
                acc   = e_wr;
            end
        end
        check("in_ready", 32'(bus.in_ready), 32'(e_rdy));
        check("dbg_wr",   32'(bus.dbg_wr),   32'(e_wr));
        check("grant",    32'(bus.grant),    32'(e_gnt));
        check("busy",     32'(bus.busy),     32'(e_busy));
        if (e_wr) check("dbg_msg", 32'(bus.dbg_msg), 32'(e_msg));

        if (m_owner < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
                if (v[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            m_cnt = 0;
            m_tag_due = TAG_ON && (m_owner >= 0);
        end else if (m_tag_due) begin
            if (!ff) m_tag_due = 1'b0;
        end else if (acc) begin
            head[m_owner]++;
            m_cnt++;
            if (l[m_owner] || m_cnt == ML) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic apply_reset(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            reset = 1'b1;
            bus.in_valid = '0;
            bus.in_last  = '0;
            bus.in_data  = '0;
            bus.dbg_full = 1'b1;
        end
        m_owner = -1;
        m_ptr = 0;
        m_cnt = 0;
        m_tag_due = 1'b0;
    endtask

    initial begin
        int pos, len;
        reset = 1'b1;
        bus.in_valid = '0;
        bus.in_data  = '0;
        bus.in_last  = '0;
        bus.dbg_full = 1'b0;
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            pos = 0;
            while (pos < QLEN) begin
                len = $urandom_range(1, 6);
                for (int b = 0; b < len && pos < QLEN; b++) begin
                    lane_mem[i][pos] = {(b == len - 1), 8'($urandom)};
                    pos++;
                end
            end
        end
        apply_reset(2);

        @(negedge clk);
        reset = 1'b0;
        bus.dbg_full = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'h0);
        check("rst_dbg_wr",   32'(bus.dbg_wr),   32'h0);
        check("rst_dbg_msg",  32'(bus.dbg_msg),  32'h0);
        check("rst_grant",    32'(bus.grant),    32'h0);
        check("rst_busy",     32'(bus.busy),     32'h0);

        for (int c = 0; c < 300; c++) step(1'b0);
        for (int c = 0; c < 5; c++) step(1'b1);
        for (int c = 0; c < 200; c++) step(1'b0);

        begin
            int guard;
            guard = 0;
            while (!(m_owner >= 0 && !m_tag_due && m_cnt >= 1) && guard < 300) begin
                step(1'b0);
                guard++;
            end
            check("midmsg_reached", 32'(guard < 300), 32'h1);
        end
        apply_reset(1);
        for (int c = 0; c < 300; c++) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_dbg_arb.md
# uart_dbg_arb

Round-robin arbiter that lets several debug sources share one `uart_dbg` message queue without interleaving their bytes. Each requester presents a byte stream framed by a `last` flag. The arbiter locks onto one requester for a whole message and forwards its bytes into the queue's `wr`/`msg` port, throttled by the queue's `full`. It sits between the design's debug producers (state dumps, error reporters) and the single `uart_dbg` instance driving the board TX pin.

## Interface
- `NUM_REQ`, default 4: number of requesters, legal range 2..10.
- `MAX_LEN`, default 64: maximum bytes per grant before forced release, legal range 2..255.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `in_valid` in NUM_REQ: requester i has a byte on its lane.
- `in_data` in 8*NUM_REQ: byte lanes; lane i is `in_data[8*i+:8]`.
- `in_last` in NUM_REQ: the lane-i byte is the final byte of its message.
- `in_ready` out NUM_REQ: lane-i byte is accepted this cycle (valid & ready).
- `dbg_wr` out 1: write strobe to the `uart_dbg` `wr` port.
- `dbg_msg` out 8: byte to the `uart_dbg` `msg` port.
- `dbg_full` in 1: connected to `uart_dbg` `full`.
- `grant` out NUM_REQ: one-hot owner of the queue; all zero when idle.
- `busy` out 1: a message is in progress (state ≠ IDLE).

One clock; reset is synchronous and active-high (`clk`, `reset`).

## Operation
- The FSM has three states: IDLE, TAG, and XFER. TAG exists only with `UART_DBG_ARB_TAG_EN`.
- Registers:
  - `state`
  - `gnt_idx` (current owner)
  - `rr_ptr` (highest-priority index)
  - `len_cnt` (8-bit count of bytes forwarded in this grant)
- IDLE:
  - If any `in_valid` bit is set, select the first set index scanning `rr_ptr`, `rr_ptr+1`, … with wrap modulo NUM_REQ.
  - Register `gnt_idx`, clear `len_cnt`, and go to TAG, or to XFER if TAG is compiled out.
  - No byte is accepted in IDLE.
- TAG:
  - When `~dbg_full`, assert `dbg_wr` with `dbg_msg = 8'h30 + gnt_idx` (ASCII digit), then go to XFER.
  - Otherwise stay in TAG.
- XFER:
  - `in_ready[gnt_idx] = ~dbg_full`.
  - `dbg_wr = in_valid[gnt_idx] & ~dbg_full`.
  - `dbg_msg = in_data` lane `gnt_idx`.
  - On each accepted byte, increment `len_cnt`.
  - The grant ends on accepting a byte with `in_last` set, or on accepting the byte that makes `len_cnt == MAX_LEN` (forced release; the requester's remaining bytes form a new message).
  - On grant end: go to IDLE and set `rr_ptr = (gnt_idx+1) mod NUM_REQ`.
- A requester dropping `in_valid` mid-message keeps its grant; the arbiter waits indefinitely.
- `in_ready` for non-granted lanes is always 0.
- `dbg_wr` is never asserted while `dbg_full` is high, so the queue never overflows.

## Timing
- Reset values:
  - `state` = IDLE, `rr_ptr` = 0, `gnt_idx` = 0, `len_cnt` = 0.
  - `in_ready` = 0, `dbg_wr` = 0, `dbg_msg` = 0, `grant` = 0, `busy` = 0.
- `in_ready`, `dbg_wr` and `dbg_msg` are combinational from state, `gnt_idx`, `in_valid` and `dbg_full`. There is zero latency from `dbg_full` deasserting to the next write.
- Arbitration latency:
  - Tag compiled out: the first byte is written 1 cycle after `in_valid` is seen in IDLE.
  - Tag compiled in: the tag is written 1 cycle after, and the first payload byte 2 cycles after.
- Back-to-back messages cost one IDLE cycle between them.
- Peak throughput is 1 byte/cycle in XFER.
- A request arriving in the same cycle the current grant ends is arbitrated in the following IDLE cycle with the updated `rr_ptr`.
- If `reset` is asserted mid-message, all state returns to reset values on the next edge. Unaccepted bytes stay with the requester. A partial message may remain in the queue and is not scrubbed.

## Configuration
- `UART_DBG_ARB_TAG_EN`
  - Defined: each grant starts with one source-ID byte (`'0'+gnt_idx`) written through the TAG state, so host logs identify the sender. The tag does not count toward `len_cnt`.
  - Undefined: the TAG state and its logic are absent, IDLE goes directly to XFER, and only payload bytes are written.

## Structure
- Shared package `uart_dbg_pkg` holds:
  - the state encoding constants (IDLE, TAG, XFER)
  - the tag base constant `8'h30`
  - the `clog2` helper used to size `gnt_idx` and `rr_ptr`
- Sub-module `rr_pick`: combinational rotating-priority encoder taking the `in_valid` vector and `rr_ptr`, and returning index plus `any` flag. It is reused by any later shared-resource arbiter.

## Test plan
- Single requester, tag off: lane 2 sends 0x48, 0x69 (last) with `dbg_full` = 0. Expect `dbg_wr` on consecutive cycles with bytes 0x48, 0x69, then `grant` returns to 0 and `rr_ptr` = 3.
- Contention with no interleave: lanes 0 and 1 each present a 3-byte message simultaneously. Expect all lane-0 bytes, one idle cycle, then all lane-1 bytes. A second simultaneous round grants lane 0 only after lane 1 has been served (`rr_ptr` = 2).
- Backpressure: hold `dbg_full` = 1 for 5 cycles mid-message. Expect `dbg_wr` = 0 and `in_ready` = 0 throughout, and byte order preserved after release.
- Forced release: with `MAX_LEN` = 4, lane 0 streams 6 bytes with `last` only on byte 6. Expect a release after byte 4. If lane 3 is waiting, it is granted next, and bytes 5–6 of lane 0 follow in a later grant.
- Tag on: lane 3 sends 0x41 (last). Expect queue writes 0x33 then 0x41, with the tag 1 cycle after the IDLE decision.
- Reset mid-message: assert `reset` after byte 1 of 3. Expect all outputs at reset values the next cycle, `rr_ptr` = 0, and the requester retaining bytes 2–3.
